// File: rtl/spu_fetch_pair_buffer.sv
// spu_fetch_pair_buffer: IF-side fetch engine and pair queue for the
// dual-issue SPU decoder.
// Ports: clk, reset (async, active-high); enable/flush/flush_target from
//   decode; imem_req/imem_addr out, imem_rvalid/imem_rdata back from
//   instruction memory; instruction1/instruction2/pair_valid present the
//   head pair; fetch_pc is the address of the next request.
module spu_fetch_pair_buffer #(
  parameter int               DEPTH           = 4,
  parameter int               MAX_OUTSTANDING = 2,
  parameter int               ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter logic [31:0]      NOP_INSN        = 32'h40200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [63:0]       imem_rdata,
  output logic [31:0]       instruction1,
  output logic [31:0]       instruction2,
  output logic              pair_valid,
  output logic [ADDR_W-1:0] fetch_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [63:0]       pairMem [DEPTH];
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     wrPtr;
  logic [CW-1:0]     count;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     discard;
  logic              kill;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] alignedPc;
  logic              creditFree;
  logic              slotFree;
  logic              drop;
  logic              doEnq;
  logic              doDeq;
  logic [63:0]       headPair;

  assign alignedPc = {pc[ADDR_W-1:3], 3'b000};

  // Stale (discarded) requests still occupy the memory pipe, so they
  // count against the in-flight credit but not against FIFO space.
  assign creditFree =
    (32'(outstanding) + 32'(discard)) < 32'(MAX_OUTSTANDING);
  assign slotFree =
    (32'(count) + 32'(outstanding)) < 32'(DEPTH);

  assign imem_req  = !reset && !flush && creditFree && slotFree;
  assign imem_addr = alignedPc;
  assign fetch_pc  = pc;

  assign drop  = imem_rvalid && (discard != '0);
  assign doEnq = imem_rvalid && !drop && !flush;
  assign doDeq = enable && pair_valid && !flush;

  assign pair_valid   = (count != '0);
  assign headPair     = pairMem[rdPtr];
  assign instruction1 = pair_valid ? headPair[63:32] : NOP_INSN;
  assign instruction2 = pair_valid ? headPair[31:0]  : NOP_INSN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      kill        <= 1'b0;
      pc          <= RESET_PC;
    end else if (flush) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      // Everything still in the memory pipe becomes stale; a response
      // landing this cycle has already left the pipe.
      discard     <= discard + outstanding - OW'(imem_rvalid);
      outstanding <= '0;
      pc          <= flush_target;
      kill        <= flush_target[2];
    end else begin
      if (imem_req) begin
        pc <= alignedPc + ADDR_W'(8);
      end
      if (drop) begin
        discard <= discard - OW'(1);
      end
      if (doEnq) begin
        wrPtr <= wrPtr + PW'(1);
        kill  <= 1'b0;
      end
      if (doDeq) begin
        rdPtr <= rdPtr + PW'(1);
      end
      outstanding <= outstanding + OW'(imem_req) - OW'(doEnq);
      count       <= count + CW'(doEnq) - CW'(doDeq);
    end
  end

  // A target in the odd word of a pair must not execute the even word.
  always_ff @(posedge clk) begin
    if (doEnq) begin
      pairMem[wrPtr] <= {kill ? NOP_INSN : imem_rdata[63:32],
                         imem_rdata[31:0]};
    end
  end

endmodule

// File: tb/tb_spu_fetch_pair_buffer.sv
// tb_spu_fetch_pair_buffer: scoreboard bench for the fetch pair buffer.
// Memory model answers {addr, addr+4}; a transaction model predicts pairs.
module tb_spu_fetch_pair_buffer;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h40200000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expAddr;
    int          epoch;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_target = '0;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instruction1;
  logic [31:0] instruction2;
  logic        pair_valid;
  logic [31:0] fetch_pc;

  req_t        memQ[$];
  logic [63:0] expQ[$];
  logic [31:0] modelPc = RESET_PC;
  bit          killPending = 1'b0;
  bit          randLat = 1'b0;
  bit          flushed = 1'b0;
  bit          predReq;
  int          epoch = 0;
  int          cyc = 0;
  int          lat = 1;
  int          errors = 0;
  int          checks = 0;

  spu_fetch_pair_buffer #(
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_W(32),
    .RESET_PC(RESET_PC),
    .NOP_INSN(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .flush(flush),
    .flush_target(flush_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instruction1(instruction1),
    .instruction2(instruction2),
    .pair_valid(pair_valid),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int liveInFlight();
    int n = 0;
    foreach (memQ[i]) if (memQ[i].epoch == epoch) n++;
    return n;
  endfunction

  // Monitor: compares the DUT against the model once inputs settle.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      predReq = !flush && memQ.size() < MAXO &&
                (expQ.size() + liveInFlight()) < DEPTH;
      chk("imem_req", 64'(imem_req), 64'(predReq));
      if (imem_req)
        chk("imem_addr", 64'(imem_addr), 64'({modelPc[31:3], 3'b000}));
      chk("fetch_pc", 64'(fetch_pc), 64'(modelPc));
      chk("pair_valid", 64'(pair_valid), 64'(expQ.size() != 0));
      if (pair_valid && expQ.size() != 0) begin
        chk("head_pair", {instruction1, instruction2}, expQ[0]);
        if (enable && !flush) void'(expQ.pop_front());
      end else if (!pair_valid) begin
        chk("empty_slots", {instruction1, instruction2}, {NOP, NOP});
      end
    end
  end

  // Driver, memory model and reference model for one clock cycle.
  task automatic cycle(input bit en, input bit fl, input logic [31:0] tgt,
                       input bit flOnRv, input bit rst);
    bit   rv;
    req_t r;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    rv = memQ.size() != 0 && memQ[0].due <= cyc;
    imem_rvalid = rv;
    imem_rdata  = rv ? {memQ[0].addr, memQ[0].addr + 32'd4} : 64'h0;
    enable = en;
    flush = fl || (flOnRv && rv);
    flush_target = tgt;
    flushed = flush;
    #2;
    if (rst) begin
      #1;
      reset = 1'b1;
      #1;
      chk("rst_pair_valid", 64'(pair_valid), 64'(0));
      chk("rst_slots", {instruction1, instruction2}, {NOP, NOP});
      chk("rst_req", 64'(imem_req), 64'(0));
      chk("rst_fetch_pc", 64'(fetch_pc), 64'(RESET_PC));
      memQ.delete();
      expQ.delete();
      modelPc = RESET_PC;
      killPending = 1'b0;
      imem_rvalid = 1'b0;
      enable = 1'b0;
      flush = 1'b0;
    end else begin
      if (flush) begin
        expQ.delete();
        epoch++;
        modelPc = flush_target;
        killPending = flush_target[2];
      end else if (rv && memQ[0].epoch == epoch) begin
        expQ.push_back({killPending ? NOP : memQ[0].expAddr,
                        memQ[0].expAddr + 32'd4});
        killPending = 1'b0;
      end
      if (rv) void'(memQ.pop_front());
      if (imem_req) begin
        r.addr    = imem_addr;
        r.expAddr = {modelPc[31:3], 3'b000};
        r.epoch   = epoch;
        r.due     = cyc + (randLat ? int'($urandom_range(1, 4)) : lat);
        memQ.push_back(r);
        if (!flush) modelPc = {modelPc[31:3], 3'b000} + 32'd8;
      end
    end
  endtask

  initial begin
    int n;
    #3;
    chk("reset_pair_valid", 64'(pair_valid), 64'(0));
    chk("reset_slots", {instruction1, instruction2}, {NOP, NOP});
    chk("reset_req", 64'(imem_req), 64'(0));
    chk("reset_fetch_pc", 64'(fetch_pc), 64'(RESET_PC));

    lat = 1;
    repeat (20) cycle(1, 0, 0, 0, 0);

    repeat (12) cycle(0, 0, 0, 0, 0);
    repeat (12) cycle(1, 0, 0, 0, 0);

    lat = 3;
    repeat (6) cycle(1, 0, 0, 0, 0);
    n = 0;
    while (memQ.size() != 2 && n < 20) begin
      cycle(1, 0, 0, 0, 0);
      n++;
    end
    chk("wait_two_inflight", 64'(memQ.size()), 64'(2));
    cycle(1, 1, 32'h100, 0, 0);
    repeat (20) cycle(1, 0, 0, 0, 0);

    cycle(1, 1, 32'h204, 0, 0);
    repeat (15) cycle(1, 0, 0, 0, 0);

    lat = 1;
    repeat (5) cycle(1, 0, 0, 0, 0);
    n = 0;
    flushed = 1'b0;
    while (!flushed && n < 10) begin
      cycle(1, 0, 32'h340, 1, 0);
      n++;
    end
    chk("flush_on_rvalid_seen", 64'(flushed), 64'(1));
    repeat (10) cycle(1, 0, 0, 0, 0);

    n = 0;
    while (expQ.size() != 3 && n < 20) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    chk("wait_three_queued", 64'(expQ.size()), 64'(3));
    cycle(0, 0, 0, 0, 1);
    repeat (15) cycle(1, 0, 0, 0, 0);

    randLat = 1'b1;
    repeat (600) begin
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0,
            32'($urandom_range(0, 255)) << 2,
            1'b0,
            $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/spu_fetch_pair_buffer.md
Name: spu_fetch_pair_buffer

Overview:
- Producer end of the IF→ID instruction-pair interface of the dual-issue SPU pipeline.
- Issues 64-bit fetches to instruction memory and queues the returned pairs in a FIFO.
- Presents one pair per cycle to decode as instruction1 (even pipe) and instruction2 (odd pipe).
- Holds its output under decode stall (enable low) and redirects on flush.

Parameters:
- DEPTH, 4, FIFO depth in instruction pairs; power of 2, at least 2.
- MAX_OUTSTANDING, 2, maximum fetch requests in flight.
- ADDR_W, 32, byte address width.
- RESET_PC, 0, byte address fetched after reset; 8-byte aligned.
- NOP_INSN, 32'h40200000, encoding driven into empty or killed slots.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  decode accepts the head pair this cycle; equals ~nop from forwarding control
- flush  input  1  redirect request; discards all queued and in-flight pairs
- flush_target  input  ADDR_W  byte address to resume at; word aligned
- imem_req  output  1  one-cycle fetch request pulse
- imem_addr  output  ADDR_W  8-byte-aligned fetch address, valid while imem_req is high
- imem_rvalid  input  1  response valid; responses return in request order, at least 1 cycle after the request
- imem_rdata  input  64  [63:32] is the lower-address word, [31:0] is the higher-address word
- instruction1  output  32  even-slot instruction of the head pair
- instruction2  output  32  odd-slot instruction of the head pair
- pair_valid  output  1  head pair holds real instructions
- fetch_pc  output  ADDR_W  byte address of the next request

Behaviour:
- Reset (asynchronous):
  - FIFO empty; outstanding count = 0; discard count = 0; kill flag = 0.
  - fetch_pc = RESET_PC; imem_req = 0; pair_valid = 0.
  - instruction1 = instruction2 = NOP_INSN.
- Request issue:
  - imem_req = 1 in a cycle when !flush, outstanding + discard < MAX_OUTSTANDING, and fifo_count + outstanding < DEPTH. FIFO space is reserved per request, so an accepted response is always enqueued.
  - imem_addr = fetch_pc & ~7.
  - After issue, fetch_pc ← (fetch_pc & ~7) + 8, wrapping modulo 2^ADDR_W.
  - The memory always accepts a request; there is no grant signal.
- Response:
  - On imem_rvalid with discard > 0: data dropped, discard decrements.
  - Otherwise: outstanding decrements and the pair is enqueued as {rdata[63:32], rdata[31:0]}.
  - If the kill flag is set, slot 1 of the enqueued pair is replaced by NOP_INSN and the kill flag clears.
- Output:
  - instruction1/2 and pair_valid are driven combinationally from the FIFO head.
  - When the FIFO is empty: pair_valid = 0 and both instruction outputs = NOP_INSN.
- Dequeue: occurs when enable && pair_valid.
  - enable low: head pair and all outputs hold.
  - enable high on an empty FIFO: no effect.
- Simultaneous enqueue and dequeue: both occur; count unchanged. Permitted when full only because space was reserved.
- Flush (synchronous, highest priority):
  - FIFO emptied; pair_valid = 0 the next cycle.
  - discard ← discard + outstanding − (rvalid this cycle ? 1 : 0); outstanding ← 0.
  - A response arriving in the flush cycle is dropped.
  - fetch_pc ← flush_target; kill flag ← flush_target[2].
  - No request is issued in the flush cycle. Dequeue in the flush cycle is ignored.
- Back-to-back flushes: discard accumulates; the last target wins.
  - If kill was set by an earlier flush and a new flush has target[2] = 0, kill clears.
- Requests resume only once outstanding + discard < MAX_OUTSTANDING. Stale responses never reach the FIFO.
- Counter widths must cover DEPTH and MAX_OUTSTANDING without overflow.
- Any reset assertion mid-operation returns all state to reset values immediately.
  - Responses to requests issued before reset are the memory's responsibility; the bench drains the memory model on reset.

Test Plan:
- Reset, then 1-cycle-latency memory returning {addr, addr+4} with enable = 1: requests at 0x0, 0x8, 0x10, …; first pair_valid 2 cycles after the first imem_req; instruction1 = 0x0, instruction2 = 0x4, then 0x8/0xC, one pair per cycle.
- Hold enable = 0 with DEPTH = 4: fetches stop after the FIFO plus in-flight requests reach 4 pairs; head stays 0x0/0x4; when enable rises, pairs drain in order with no loss or duplication.
- Memory latency 3 cycles, flush to 0x100 with 2 requests outstanding: both stale responses dropped; next request addr = 0x100 issued only after in-flight count allows; first valid pair = 0x100/0x104.
- Flush to 0x204: request addr = 0x200; first pair instruction1 = NOP_INSN, instruction2 = 0x204; next pair 0x208/0x20C.
- Flush in the same cycle as imem_rvalid and enable = 1: response dropped, nothing dequeued, pair_valid = 0 the next cycle; discard count correct, proven by the following pair being from the target.
- Assert reset mid-stream with 3 pairs queued: outputs immediately NOP_INSN with pair_valid = 0; after release, first request addr = RESET_PC.
